// File: rtl/prbs16_galois_checker.sv
// prbs16_galois_checker: self-synchronising checker for a 16-bit Galois LFSR
// PRBS stream (x^16 + x^5 + x^4 + x^3 + 1).
// Hunts for a non-zero seed word, confirms LOCK_CNT consecutive predicted
// words, then free-runs a local LFSR and counts mismatching words.
// Build option: define PRBS_CHK_BITERR_EN to accumulate bit errors
// (popcount of the difference) instead of word errors in err_cnt.
`timescale 1ns/1ps

module prbs16_galois_checker #(
    parameter int unsigned LOCK_CNT = 8,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             rstb,
    input  logic             data_valid,
    input  logic [15:0]      data_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MATCH_W = 8;
    localparam int unsigned POP_W   = 5;
    // Wide enough to hold a full counter plus the largest single increment.
    localparam int unsigned SUM_W   = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [MATCH_W-1:0] LOCK_THR = MATCH_W'(LOCK_CNT);
    localparam logic [MATCH_W-1:0] LOSS_THR = MATCH_W'(LOSS_CNT);

    // Galois advance by one step of the generator polynomial.
    function automatic logic [DATA_W-1:0] f_step(input logic [DATA_W-1:0] s);
        f_step = {s[14:5],
                  s[4] ^ s[15],
                  s[3] ^ s[15],
                  s[2] ^ s[15],
                  s[1],
                  s[0],
                  s[15]};
    endfunction

    // State and status registers.
    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_exp;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [MATCH_W-1:0] r_miss_cnt;
    logic               r_locked;
    logic               r_err_flag;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_word_cnt;

    // Next-state values.
    logic [1:0]         w_state_nxt;
    logic [DATA_W-1:0]  w_exp_nxt;
    logic [MATCH_W-1:0] w_match_nxt;
    logic [MATCH_W-1:0] w_miss_nxt;
    logic               w_locked_nxt;
    logic               w_err_flag_nxt;
    logic [CNT_W-1:0]   w_err_cnt_nxt;
    logic [CNT_W-1:0]   w_word_cnt_nxt;

    // Datapath helpers.
    logic               w_match;
    logic               w_zero;
    logic [DATA_W-1:0]  w_step_data;
    logic [DATA_W-1:0]  w_step_exp;
    logic [MATCH_W-1:0] w_match_inc;
    logic [MATCH_W-1:0] w_miss_inc;
    logic               w_cnt_word;
    logic               w_cnt_err;
    logic [SUM_W-1:0]   w_err_inc;
    logic [SUM_W-1:0]   w_err_sum;

    assign w_match     = (data_in == r_exp);
    assign w_zero      = (data_in == '0);
    assign w_step_data = f_step(data_in);
    assign w_step_exp  = f_step(r_exp);
    assign w_match_inc = r_match_cnt + MATCH_W'(1);
    assign w_miss_inc  = r_miss_cnt + MATCH_W'(1);

`ifdef PRBS_CHK_BITERR_EN
    logic [DATA_W-1:0] w_diff;
    logic [POP_W-1:0]  w_popcnt;

    assign w_diff = data_in ^ r_exp;

    // Number of bit positions that differ from the prediction.
    always_comb begin
        w_popcnt = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            w_popcnt = w_popcnt + POP_W'(w_diff[i]);
        end
    end

    assign w_err_inc = SUM_W'(w_popcnt);
`else
    assign w_err_inc = SUM_W'(1);
`endif

    assign w_err_sum = SUM_W'(r_err_cnt) + w_err_inc;

    // Acquisition / tracking FSM; only valid words advance anything.
    always_comb begin
        w_state_nxt    = r_state;
        w_exp_nxt      = r_exp;
        w_match_nxt    = r_match_cnt;
        w_miss_nxt     = r_miss_cnt;
        w_locked_nxt   = r_locked;
        w_err_flag_nxt = 1'b0;
        w_cnt_word     = 1'b0;
        w_cnt_err      = 1'b0;

        if (data_valid) begin
            case (r_state)
                ST_HUNT: begin
                    // All-zero is not a reachable LFSR state; never seed from it.
                    if (!w_zero) begin
                        w_exp_nxt   = w_step_data;
                        w_match_nxt = '0;
                        w_state_nxt = ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    if (w_match) begin
                        w_exp_nxt   = w_step_data;
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == LOCK_THR) begin
                            w_state_nxt  = ST_LOCKED;
                            w_locked_nxt = 1'b1;
                            w_miss_nxt   = '0;
                        end
                    end else if (w_zero) begin
                        w_match_nxt = '0;
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_exp_nxt   = w_step_data;
                        w_match_nxt = '0;
                    end
                end

                ST_LOCKED: begin
                    // Free-running prediction: corrupted words never reseed.
                    w_exp_nxt  = w_step_exp;
                    w_cnt_word = 1'b1;
                    if (w_match) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_flag_nxt = 1'b1;
                        w_cnt_err      = 1'b1;
                        w_miss_nxt     = w_miss_inc;
                        if (w_miss_inc == LOSS_THR) begin
                            w_state_nxt  = ST_HUNT;
                            w_locked_nxt = 1'b0;
                        end
                    end
                end

                default: begin
                    w_state_nxt  = ST_HUNT;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end
    end

    // Saturating counters; a clear wins over a coincident increment.
    always_comb begin
        w_err_cnt_nxt  = r_err_cnt;
        w_word_cnt_nxt = r_word_cnt;

        if (clr_cnt) begin
            w_err_cnt_nxt  = '0;
            w_word_cnt_nxt = '0;
        end else begin
            if (w_cnt_err) begin
                if (w_err_sum > SUM_W'(CNT_MAX)) begin
                    w_err_cnt_nxt = CNT_MAX;
                end else begin
                    w_err_cnt_nxt = CNT_W'(w_err_sum);
                end
            end
            if (w_cnt_word && (r_word_cnt != CNT_MAX)) begin
                w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_HUNT;
            r_exp       <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_cnt   <= '0;
            r_word_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp       <= w_exp_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_locked    <= w_locked_nxt;
            r_err_flag  <= w_err_flag_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
        end
    end

    assign locked   = r_locked;
    assign err_flag = r_err_flag;
    assign err_cnt  = r_err_cnt;
    assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_prbs16_galois_checker.sv
// Bench for prbs16_galois_checker: a vector table for acquisition and single
// errors, hand sequences for lock loss / saturation / clear / reset, then a
// randomized stream checked against a behavioural model. Two instances run in
// parallel: default counter width and a 4-bit one to exercise saturation.
`timescale 1ns/1ps

module tb_prbs16_galois_checker;

    localparam int unsigned LOCK_CNT = 8;
    localparam int unsigned LOSS_CNT = 4;
`ifdef PRBS_CHK_BITERR_EN
    localparam int unsigned F0_INC = 4;
`else
    localparam int unsigned F0_INC = 1;
`endif

    localparam int M_HUNT   = 0;
    localparam int M_SYNC   = 1;
    localparam int M_LOCKED = 2;

    logic        CLK;
    logic        rstb;
    logic        data_valid;
    logic [15:0] data_in;
    logic        clr_cnt;
    logic        locked,   err_flag;
    logic [31:0] err_cnt,  word_cnt;
    logic        locked4,  err_flag4;
    logic [3:0]  err_cnt4, word_cnt4;

    int n_vec = 0;
    int n_bad = 0;

    prbs16_galois_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(32)) u_dut (
        .CLK(CLK), .rstb(rstb), .data_valid(data_valid), .data_in(data_in),
        .clr_cnt(clr_cnt), .locked(locked), .err_flag(err_flag),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    prbs16_galois_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(4)) u_dut4 (
        .CLK(CLK), .rstb(rstb), .data_valid(data_valid), .data_in(data_in),
        .clr_cnt(clr_cnt), .locked(locked4), .err_flag(err_flag4),
        .err_cnt(err_cnt4), .word_cnt(word_cnt4)
    );

    always #5 CLK = ~CLK;

    // Next PRBS word: multiply by x modulo x^16+x^5+x^4+x^3+1.
    function automatic logic [15:0] mul_x(input logic [15:0] s);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ 17'h1_0039;
        return t[15:0];
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return ((a + b) > mx) ? mx : (a + b);
    endfunction

    // Behavioural reference model.
    int          m_mode;
    logic [15:0] m_exp;
    int          m_match, m_miss;
    bit          m_locked, m_flag;
    longint      m_err, m_words, m_err4, m_words4;

    task automatic model_reset();
        m_mode = M_HUNT; m_exp = 16'h0; m_match = 0; m_miss = 0;
        m_locked = 0; m_flag = 0;
        m_err = 0; m_words = 0; m_err4 = 0; m_words4 = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit c);
        int inc_e;
        int inc_w;
        inc_e  = 0;
        inc_w  = 0;
        m_flag = 0;
        if (v) begin
            if (m_mode == M_HUNT) begin
                if (d != 16'h0) begin
                    m_exp = mul_x(d); m_match = 0; m_mode = M_SYNC;
                end
            end else if (m_mode == M_SYNC) begin
                if (d == m_exp) begin
                    m_exp = mul_x(d);
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_mode = M_LOCKED; m_locked = 1; m_miss = 0;
                    end
                end else if (d == 16'h0) begin
                    m_mode = M_HUNT; m_match = 0;
                end else begin
                    m_exp = mul_x(d); m_match = 0;
                end
            end else begin
                inc_w = 1;
                if (d != m_exp) begin
                    m_flag = 1;
`ifdef PRBS_CHK_BITERR_EN
                    inc_e = $countones(d ^ m_exp);
`else
                    inc_e = 1;
`endif
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_mode = M_HUNT; m_locked = 0;
                    end
                end else begin
                    m_miss = 0;
                end
                m_exp = mul_x(m_exp);
            end
        end
        if (c) begin
            m_err = 0; m_words = 0; m_err4 = 0; m_words4 = 0;
        end else begin
            m_err    = sat_add(m_err,    longint'(inc_e), 32);
            m_words  = sat_add(m_words,  longint'(inc_w), 32);
            m_err4   = sat_add(m_err4,   longint'(inc_e), 4);
            m_words4 = sat_add(m_words4, longint'(inc_w), 4);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        check("locked",    64'(locked),    64'(m_locked));
        check("err_flag",  64'(err_flag),  64'(m_flag));
        check("err_cnt",   64'(err_cnt),   64'(m_err));
        check("word_cnt",  64'(word_cnt),  64'(m_words));
        check("locked4",   64'(locked4),   64'(m_locked));
        check("err_flag4", 64'(err_flag4), 64'(m_flag));
        check("err_cnt4",  64'(err_cnt4),  64'(m_err4));
        check("word_cnt4", 64'(word_cnt4), 64'(m_words4));
    endtask

    // Drive one cycle; outputs are sampled 1ns after the rising edge.
    task automatic drive(input bit v, input logic [15:0] d, input bit c);
        data_valid = v;
        data_in    = d;
        clr_cnt    = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply(input bit v, input logic [15:0] d, input bit c);
        drive(v, d, c);
        model_step(v, d, c);
        check_model();
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        data_valid = 1'b0; data_in = 16'h0; clr_cnt = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        rstb = 1'b1;
        model_reset();
        check_model();
    endtask

    typedef struct {
        bit          valid;
        logic [15:0] xmask;
        bit          clr;
        bit          exp_locked;
        bit          exp_flag;
        int unsigned exp_err;
        int unsigned exp_words;
    } vec_t;

    function automatic vec_t mk(input bit v, input logic [15:0] m, input bit c,
                                input bit l, input bit f, input int unsigned e,
                                input int unsigned w);
        vec_t r;
        r.valid = v; r.xmask = m; r.clr = c;
        r.exp_locked = l; r.exp_flag = f; r.exp_err = e; r.exp_words = w;
        return r;
    endfunction

    vec_t        tbl[21];
    logic [15:0] g;
    logic [15:0] d;
    logic [15:0] msk;
    int          burst;

    initial begin
        // Acquisition from 0xFFFF, one flipped bit, a 5-cycle gap,
        // a 0x00F0 corruption and a clear coincident with an error.
        for (int i = 0; i < 8; i++) tbl[i] = mk(1, 16'h0000, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 16'h0000, 0, 1, 0, 0, 0);
        tbl[9]  = mk(1, 16'h0000, 0, 1, 0, 0, 1);
        tbl[10] = mk(1, 16'h0001, 0, 1, 1, 1, 2);
        tbl[11] = mk(1, 16'h0000, 0, 1, 0, 1, 3);
        for (int i = 12; i < 17; i++) tbl[i] = mk(0, 16'h0000, 0, 1, 0, 1, 3);
        tbl[17] = mk(1, 16'h0000, 0, 1, 0, 1, 4);
        tbl[18] = mk(1, 16'h00F0, 0, 1, 1, 1 + F0_INC, 5);
        tbl[19] = mk(1, 16'h0001, 1, 1, 1, 0, 0);
        tbl[20] = mk(1, 16'h0000, 0, 1, 0, 0, 1);

        CLK = 1'b0;
        do_reset();

        // Table-driven phase.
        g = 16'hFFFF;
        d = 16'h0000;
        for (int i = 0; i < 21; i++) begin
            if (tbl[i].valid) begin
                d = g ^ tbl[i].xmask;
                g = mul_x(g);
            end
            drive(tbl[i].valid, d, tbl[i].clr);
            check($sformatf("tbl%0d.locked", i),    64'(locked),    64'(tbl[i].exp_locked));
            check($sformatf("tbl%0d.err_flag", i),  64'(err_flag),  64'(tbl[i].exp_flag));
            check($sformatf("tbl%0d.err_cnt", i),   64'(err_cnt),   64'(tbl[i].exp_err));
            check($sformatf("tbl%0d.word_cnt", i),  64'(word_cnt),  64'(tbl[i].exp_words));
            check($sformatf("tbl%0d.err_cnt4", i),  64'(err_cnt4),  64'(tbl[i].exp_err));
            check($sformatf("tbl%0d.word_cnt4", i), 64'(word_cnt4), 64'(tbl[i].exp_words));
        end

        // Zero word in HUNT is ignored.
        do_reset();
        apply(1, 16'h0000, 0);
        apply(1, 16'h0000, 0);
        check("hunt_zero_locked", 64'(locked), 64'(0));

        // Acquire, then lose lock on the 4th consecutive corrupted word.
        g = 16'hACE1;
        for (int i = 0; i < 9; i++) begin
            apply(1, g, 0); g = mul_x(g);
            if (i == 7) check("acq_pre_lock", 64'(locked), 64'(0));
        end
        check("acq_lock", 64'(locked), 64'(1));
        repeat (2) begin apply(1, g, 0); g = mul_x(g); end
        for (int i = 0; i < 4; i++) begin
            apply(1, g ^ 16'h0001, 0); g = mul_x(g);
            if (i == 2) check("loss_still_locked", 64'(locked), 64'(1));
        end
        check("loss_locked", 64'(locked), 64'(0));
        check("loss_err_cnt", 64'(err_cnt), 64'(4));
        check("loss_word_cnt", 64'(word_cnt), 64'(6));

        // Re-lock after seed plus LOCK_CNT matches.
        for (int i = 0; i < 9; i++) begin
            apply(1, g, 0); g = mul_x(g);
            if (i == 7) check("relock_pre", 64'(locked), 64'(0));
        end
        check("relock", 64'(locked), 64'(1));

        // 20 non-consecutive errors: the 4-bit counter saturates.
        for (int i = 0; i < 20; i++) begin
            apply(1, g ^ 16'h0001, 0); g = mul_x(g);
            apply(1, g, 0);            g = mul_x(g);
        end
        check("sat_err_cnt4", 64'(err_cnt4), 64'(15));
        check("sat_err_cnt",  64'(err_cnt),  64'(24));
        check("sat_locked",   64'(locked),   64'(1));

        // Clear coincident with an error: counters zero, flag still pulses.
        apply(1, g ^ 16'h0100, 1); g = mul_x(g);
        check("clr_err_cnt",  64'(err_cnt),  64'(0));
        check("clr_err_cnt4", 64'(err_cnt4), 64'(0));
        check("clr_err_flag", 64'(err_flag), 64'(1));

        // 0x00F0 corruption weight.
        apply(1, g, 0);            g = mul_x(g);
        apply(1, g ^ 16'h00F0, 0); g = mul_x(g);
        check("f0_err_cnt", 64'(err_cnt), 64'(F0_INC));

        // Asynchronous reset mid-operation.
        rstb = 1'b0;
        #2;
        check("arst_locked",   64'(locked),   64'(0));
        check("arst_err_cnt",  64'(err_cnt),  64'(0));
        check("arst_word_cnt", 64'(word_cnt), 64'(0));
        model_reset();
        #2;
        rstb = 1'b1;
        apply(0, 16'h1234, 0);

        // Randomized stream with corruption, zeros, bursts, jumps and gaps.
        g = 16'h5A5A;
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit c;
            int r;
            v = ($urandom_range(0, 99) >= 10);
            c = ($urandom_range(0, 99) < 3);
            msk = 16'($urandom_range(1, 65535));
            if (v) begin
                if (burst > 0) begin
                    d = g ^ msk;
                    burst--;
                end else begin
                    r = int'($urandom_range(0, 99));
                    if (r < 4) begin
                        d = g ^ msk;
                    end else if (r < 6) begin
                        d = 16'h0000;
                    end else if (r < 8) begin
                        burst = int'($urandom_range(2, 4));
                        d = g ^ msk;
                    end else if (r < 9) begin
                        g = 16'($urandom_range(1, 65535));
                        d = g;
                    end else begin
                        d = g;
                    end
                end
                g = mul_x(g);
            end else begin
                d = 16'($urandom);
            end
            apply(v, d, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
